// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor, streamer error record and the channel scheduler state encoding.
package dma_pkg;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] num_bytes;
    } s_dma_desc_t;

    typedef enum logic [1:0] {
        DMA_NO_ERR        = 2'd0,
        DMA_RD_BUS_ERR    = 2'd1,
        DMA_WR_BUS_ERR    = 2'd2,
        DMA_UNALIGNED_ERR = 2'd3
    } dma_err_src_t;

    typedef struct packed {
        logic         valid;
        dma_err_src_t src;
        logic [31:0]  addr;
    } s_dma_error_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GO   = 3'd1,
        RUN  = 3'd2,
        RPT  = 3'd3,
        ERR  = 3'd4
    } sched_st_t;

endpackage

// File: rtl/dma_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after rr_ptr_i,
// searching upward and wrapping modulo NUM_CH.
module dma_rr_arb
    import dma_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   rr_ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   gnt_idx_o,
    output logic              gnt_valid_o
);

    logic [CH_W-1:0] idx;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(rr_ptr_i) + i) % NUM_CH);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx;
                gnt_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_chan_sched.sv
// Channel scheduler: round-robin picks a descriptor, strobes it into the read/write
// streamer pair, waits for both dones and reports per-channel completion or error.
module dma_chan_sched
    import dma_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0]        ch_desc_valid_i,
    input  s_dma_desc_t [NUM_CH-1:0] ch_desc_i,
    output logic [NUM_CH-1:0]        ch_desc_ready_o,
    output logic [NUM_CH-1:0]        ch_done_o,
    output logic [NUM_CH-1:0]        ch_err_o,
    output logic                     dma_go_o,
    output s_dma_desc_t              dma_desc_o,
    output logic                     rd_stream_valid_o,
    output logic                     wr_stream_valid_o,
    input  logic                     rd_stream_done_i,
    input  logic                     wr_stream_done_i,
    input  s_dma_error_t             rd_stream_err_i,
    input  s_dma_error_t             wr_stream_err_i,
    output s_dma_error_t             dma_error_o,
    output logic                     busy_o,
    output logic [CH_W-1:0]          active_ch_o
);

    sched_st_t    state_q, state_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] active_ch_q, active_ch_d;
    s_dma_desc_t  desc_q, desc_d;
    s_dma_error_t err_q, err_d;
    logic         rd_seen_q, rd_seen_d;
    logic         wr_seen_q, wr_seen_d;
    logic         err_pulse_q, err_pulse_d;

    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_valid;
    logic [NUM_CH-1:0] act_oh;

    dma_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i       (ch_desc_valid_i),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            active_ch_q <= '0;
            desc_q      <= '0;
            err_q       <= '0;
            rd_seen_q   <= 1'b0;
            wr_seen_q   <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            active_ch_q <= active_ch_d;
            desc_q      <= desc_d;
            err_q       <= err_d;
            rd_seen_q   <= rd_seen_d;
            wr_seen_q   <= wr_seen_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        active_ch_d = active_ch_q;
        desc_d      = desc_q;
        err_d       = err_q;
        rd_seen_d   = rd_seen_q;
        wr_seen_d   = wr_seen_q;
        err_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    desc_d      = ch_desc_i[gnt_idx];
                    active_ch_d = gnt_idx;
                    rr_ptr_d    = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d     = (ch_desc_i[gnt_idx].num_bytes == '0) ? RPT : GO;
                end
            end
            GO: begin
                rd_seen_d = 1'b0;
                wr_seen_d = 1'b0;
                state_d   = RUN;
            end
            RUN: begin
                // Errors beat dones in the same cycle; the read side wins if both fault.
                if (rd_stream_err_i.valid || wr_stream_err_i.valid) begin
                    err_d       = rd_stream_err_i.valid ? rd_stream_err_i : wr_stream_err_i;
                    err_pulse_d = 1'b1;
                    state_d     = ERR;
                end else begin
                    rd_seen_d = rd_seen_q | rd_stream_done_i;
                    wr_seen_d = wr_seen_q | wr_stream_done_i;
                    if (rd_seen_d && wr_seen_d) begin
                        state_d = RPT;
                    end
                end
            end
            RPT:     state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    assign act_oh = NUM_CH'(1) << active_ch_q;

    // Ready is masked by reset so the arbiter cannot expose a grant while the block is held.
    assign ch_desc_ready_o   = (state_q == IDLE && rstn) ? gnt : '0;
    assign ch_done_o         = (state_q == RPT) ? act_oh : '0;
    assign ch_err_o          = err_pulse_q ? act_oh : '0;
    assign dma_go_o          = (state_q == GO);
    assign dma_desc_o        = desc_q;
    assign rd_stream_valid_o = (state_q == RUN) && !rd_seen_q;
    assign wr_stream_valid_o = (state_q == RUN) && !wr_seen_q;
    assign dma_error_o       = err_q;
    assign busy_o            = (state_q != IDLE);
    assign active_ch_o       = active_ch_q;

endmodule
